// File: rtl/pc_tx_arbiter.sv
// Round-robin arbiter that shares the PC_TX word path among NUM_REQ word sources.
// One word is granted per IDLE visit. The block then pulses the next-word command and
// waits for the serialiser busy window before it accepts another word.
module pc_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned WORD_TIMEOUT  = 20000
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ack,
  output logic [WORD_W-1:0]          o_fifo_word_data,
  output logic                       o_serial_next_word_cmd,
  input  logic                       i_serial_is_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned CW      = ID_W + 1;
  localparam int unsigned TIMER_W = 24;
  localparam logic [TIMER_W-1:0] START_LIMIT = TIMER_W'(START_TIMEOUT);
  localparam logic [TIMER_W-1:0] WORD_LIMIT  = TIMER_W'(WORD_TIMEOUT);
  localparam logic [ID_W-1:0]    LAST_ID     = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_inc;
  logic [WORD_W-1:0]  words [NUM_REQ];
  logic [ID_W-1:0]    pick;
  logic               pick_found;
  logic [CW-1:0]      idx_sum;

  // Unpack the flat requester data bus into one word per requester
  always_comb begin
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      words[k] = i_req_data[k*WORD_W +: WORD_W];
    end
  end

  // First pending requester at or above the round-robin pointer, with wrap
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx_sum    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx_sum = CW'(rr_ptr) + CW'(i);
      if (idx_sum >= CW'(NUM_REQ)) begin
        idx_sum = idx_sum - CW'(NUM_REQ);
      end
      if (!pick_found && i_req_valid[idx_sum[ID_W-1:0]]) begin
        pick       = idx_sum[ID_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Saturating increment so a stuck serialiser can never wrap the timer
  always_comb begin
    timer_inc = (&timer) ? timer : timer + TIMER_W'(1);
  end

  // Grant / command / busy-window state machine with registered outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                  <= IDLE;
      rr_ptr                 <= '0;
      timer                  <= '0;
      o_req_ack              <= '0;
      o_fifo_word_data       <= '0;
      o_serial_next_word_cmd <= 1'b0;
      o_grant_id             <= '0;
      o_busy                 <= 1'b0;
      o_timeout_err          <= 1'b0;
    end else begin
      o_req_ack              <= '0;
      o_serial_next_word_cmd <= 1'b0;
      o_timeout_err          <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            o_fifo_word_data <= words[pick];
            o_grant_id       <= pick;
            o_req_ack        <= NUM_REQ'(1) << pick;
            rr_ptr           <= (pick == LAST_ID) ? '0 : pick + 1'b1;
            o_busy           <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          o_serial_next_word_cmd <= 1'b1;
          timer                  <= '0;
          state                  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_serial_is_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer_inc == START_LIMIT) begin
            o_timeout_err <= 1'b1;
            state         <= GAP;
          end else begin
            timer <= timer_inc;
          end
        end
        WAIT_DONE: begin
          if (!i_serial_is_busy) begin
            state <= GAP;
          end else if (timer_inc == WORD_LIMIT) begin
            o_timeout_err <= 1'b1;
            state         <= GAP;
          end else begin
            timer <= timer_inc;
          end
        end
        GAP: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_tx_arbiter.sv
// Bench for pc_tx_arbiter: a constant vector table, reset/wrap/timeout sequences and
// random traffic checked against a transaction-level round-robin model.
module tb_pc_tx_arbiter;

  localparam int N     = 4;
  localparam int ST    = 16;
  localparam int WT    = 20000;
  localparam int LIMIT = 25000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   valid;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic [31:0]  fdata;
  logic         cmd;
  logic         sbusy;
  logic [1:0]   gid;
  logic         busy;
  logic         err;

  logic [31:0] words [4];
  int total = 0;
  int bad   = 0;
  int mptr  = 0;

  typedef struct {
    logic [3:0] valid;
    int         dly;
    int         len;
    int         pulse;
    int         exp_k;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < N; k++) req_data[k*32 +: 32] = words[k];
  end

  pc_tx_arbiter #(
    .NUM_REQ(4), .WORD_W(32), .START_TIMEOUT(16), .WORD_TIMEOUT(20000)
  ) dut (
    .i_clock               (clk),
    .i_reset_n             (rst_n),
    .i_req_valid           (valid),
    .i_req_data            (req_data),
    .o_req_ack             (ack),
    .o_fifo_word_data      (fdata),
    .o_serial_next_word_cmd(cmd),
    .i_serial_is_busy      (sbusy),
    .o_grant_id            (gid),
    .o_busy                (busy),
    .o_timeout_err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference round-robin choice: first set bit scanning upward from the pointer
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[2'((p + i) % N)]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One word transaction: grant, command, serialiser busy window, return to IDLE
  task automatic serve(input int exp_k, input int dly, input int len, input int pulse);
    logic [31:0] w;
    int c, fall, errs, errc, cmds, acks;
    int exp_fall, exp_errs, exp_errc;
    w = words[exp_k];
    tick();
    check("grant_ack", longint'(ack), longint'(4'(1) << exp_k));
    check("grant_id", longint'(gid), exp_k);
    check("grant_data", longint'(fdata), longint'(w));
    check("busy_at_grant", longint'(busy), 1);
    check("cmd_early", longint'(cmd), 0);
    words[exp_k] = $urandom;
    tick();
    check("cmd_pulse", longint'(cmd), 1);
    check("ack_one_clk", longint'(ack), 0);
    c = 0; fall = -1; errs = 0; errc = -1; cmds = 0; acks = 0;
    while (fall < 0 && c < LIMIT) begin
      if (len > 0 && c == dly) sbusy = 1'b1;
      if (len > 0 && c == dly + len) sbusy = 1'b0;
      if (pulse >= 0 && c == 3) valid[2'(pulse)] = 1'b1;
      if (pulse >= 0 && c == 4) valid[2'(pulse)] = 1'b0;
      tick();
      c++;
      if (ack != 4'b0) acks++;
      if (cmd) cmds++;
      if (err) begin
        errs++;
        errc = c;
      end
      if (!busy) fall = c;
    end
    if (len == 0) begin
      exp_fall = ST + 1; exp_errs = 1; exp_errc = ST;
    end else if (len >= WT + 1) begin
      exp_fall = dly + WT + 2; exp_errs = 1; exp_errc = dly + WT + 1;
    end else begin
      exp_fall = dly + len + 2; exp_errs = 0; exp_errc = -1;
    end
    check("busy_fall_clk", fall, exp_fall);
    check("timeout_count", errs, exp_errs);
    check("timeout_clk", errc, exp_errc);
    check("extra_cmds", cmds, 0);
    check("extra_acks", acks, 0);
    check("data_held", longint'(fdata), longint'(w));
    check("id_held", longint'(gid), exp_k);
    sbusy = 1'b0;
    mptr = (exp_k + 1) % N;
  endtask

  initial begin
    logic [3:0] v;
    int k, dly, len, pulse;

    tbl[0]  = '{4'b0010,  2,    20, -1, 1};
    tbl[1]  = '{4'b1000,  1,     5,  2, 3};
    tbl[2]  = '{4'b0100,  3,     4, -1, 2};
    tbl[3]  = '{4'b0100,  0,     0, -1, 2};
    tbl[4]  = '{4'b1001, 15,     3, -1, 3};
    tbl[5]  = '{4'b1111,  0,     1, -1, 0};
    tbl[6]  = '{4'b1111,  4,     7, -1, 1};
    tbl[7]  = '{4'b1111,  2,     2, -1, 2};
    tbl[8]  = '{4'b1111,  5,     9, -1, 3};
    tbl[9]  = '{4'b1111,  1,     1, -1, 0};
    tbl[10] = '{4'b1111,  3,     6, -1, 1};
    tbl[11] = '{4'b0010,  2, 20000, -1, 1};
    tbl[12] = '{4'b0010,  1, 20001, -1, 1};

    valid = 4'b0;
    sbusy = 1'b0;
    words[0] = 32'h0A0A_0000;
    words[1] = 32'hDEAD_BEEF;
    words[2] = 32'h2C2C_2222;
    words[3] = 32'h3D3D_3333;

    // Reset state
    #12;
    check("rst_ack", longint'(ack), 0);
    check("rst_data", longint'(fdata), 0);
    check("rst_cmd", longint'(cmd), 0);
    check("rst_gid", longint'(gid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_err", longint'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // No request, no grant
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_ack", longint'(ack), 0);
      check("idle_not_busy", longint'(busy), 0);
    end

    // Constant vector table
    for (int i = 0; i < 13; i++) begin
      valid = tbl[i].valid;
      serve(tbl[i].exp_k, tbl[i].dly, tbl[i].len, tbl[i].pulse);
    end
    valid = 4'b0;
    tick();
    check("post_table_ack", longint'(ack), 0);

    // Async reset in the middle of a word, then the pointer restarts at 0
    valid = 4'b0010;
    tick();
    check("rstseq_ack", longint'(ack), 2);
    valid = 4'b0;
    tick();
    check("rstseq_cmd", longint'(cmd), 1);
    sbusy = 1'b1;
    tick();
    tick();
    tick();
    check("rstseq_busy", longint'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ack", longint'(ack), 0);
    check("async_cmd", longint'(cmd), 0);
    check("async_data", longint'(fdata), 0);
    check("async_gid", longint'(gid), 0);
    check("async_busy", longint'(busy), 0);
    check("async_err", longint'(err), 0);
    sbusy = 1'b0;
    valid = 4'b1001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mptr = 0;
    serve(0, 2, 5, -1);

    // Random traffic against the round-robin model
    for (int n = 0; n < 30; n++) begin
      v = 4'($urandom_range(1, 15));
      valid = v;
      k = rr_pick(v, mptr);
      dly = int'($urandom_range(0, 15));
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
      pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      serve(k, dly, len, pulse);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
